// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: Moore FSM driving the datapath strobes,
// with a memory-wait watchdog that parks the controller in a sticky FAULT
// state when memory never answers.
// Optional feature: define CTRL_BNE_EN to decode bne (opcode 000101) through
// the BRANCH state with o_branchNe asserted; otherwise bne is an illegal opcode.
module multicycle_control #(
  parameter int WAIT_W = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instrCode,
  input  logic        i_memReady,
  output logic        o_pcWrite,
  output logic        o_pcWriteCond,
  output logic        o_branchNe,
  output logic        o_iorD,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic        o_irWrite,
  output logic        o_memToReg,
  output logic        o_regDst,
  output logic        o_regWrite,
  output logic        o_aluSrcA,
  output logic [1:0]  o_aluSrcB,
  output logic [1:0]  o_aluOp,
  output logic [1:0]  o_pcSrc,
  output logic [5:0]  o_func,
  output logic [3:0]  o_state,
  output logic        o_fault
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IMMEX  = 4'd10,
    IMMWB  = 4'd11,
    FAULT  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [WAIT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [5:0]        opcode;
  logic              is_wait;
  logic              timeout;

  assign opcode = i_instrCode[31:26];
  assign o_func = i_instrCode[5:0];

  // Only the memory-access states can stall; every other state clears the counter.
  assign is_wait = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout = is_wait && !i_memReady && (cnt_q == CNT_MAX);
  assign cnt_d   = (is_wait && !i_memReady) ? cnt_q + WAIT_W'(1) : '0;

  // State and wait-counter registers with synchronous reset.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CTRL_BNE_EN
  logic bne_q;

  // Remember at dispatch whether the branch being taken is a bne.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bne_q <= 1'b0;
    end else if (state_q == DECODE) begin
      bne_q <= (opcode == OP_BNE);
    end
  end
`endif

  // Next-state decode; memory states advance on i_memReady or trip the watchdog.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_d = state_q;
    unique case (state_q)
      FETCH:  state_d = i_memReady ? DECODE : (timeout ? FAULT : FETCH);
      DECODE: begin
        unique case (opcode)
          OP_RTYPE:          state_d = EXEC;
          OP_LW, OP_SW:      state_d = MEMADR;
          OP_ADDI, OP_ADDIU: state_d = IMMEX;
          OP_BEQ:            state_d = BRANCH;
`ifdef CTRL_BNE_EN
          OP_BNE:            state_d = BRANCH;
`endif
          OP_J:              state_d = JUMP;
          default:           state_d = FAULT;
        endcase
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = i_memReady ? MEMWB : (timeout ? FAULT : MEMRD);
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = i_memReady ? FETCH : (timeout ? FAULT : MEMWR);
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      IMMEX:  state_d = IMMWB;
      IMMWB:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      FAULT:  state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Moore output decode; only the FETCH write strobes look at i_memReady.
  always_comb begin
    o_pcWrite     = 1'b0;
    o_pcWriteCond = 1'b0;
    o_branchNe    = 1'b0;
    o_iorD        = 1'b0;
    o_memRead     = 1'b0;
    o_memWrite    = 1'b0;
    o_irWrite     = 1'b0;
    o_memToReg    = 1'b0;
    o_regDst      = 1'b0;
    o_regWrite    = 1'b0;
    o_aluSrcA     = 1'b0;
    o_aluSrcB     = 2'b00;
    o_aluOp       = 2'b00;
    o_pcSrc       = 2'b00;
    o_fault       = 1'b0;
    unique case (state_q)
      FETCH: begin
        o_memRead = 1'b1;
        o_aluSrcB = 2'b01;
        o_irWrite = i_memReady;
        o_pcWrite = i_memReady;
      end
      DECODE: o_aluSrcB = 2'b11;
      MEMADR: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
      end
      MEMRD: begin
        o_memRead = 1'b1;
        o_iorD    = 1'b1;
      end
      MEMWB: begin
        o_regWrite = 1'b1;
        o_memToReg = 1'b1;
      end
      MEMWR: begin
        o_memWrite = 1'b1;
        o_iorD     = 1'b1;
      end
      EXEC: begin
        o_aluSrcA = 1'b1;
        o_aluOp   = 2'b10;
      end
      ALUWB: begin
        o_regWrite = 1'b1;
        o_regDst   = 1'b1;
      end
      IMMEX: begin
        o_aluSrcA = 1'b1;
        o_aluSrcB = 2'b10;
      end
      IMMWB: o_regWrite = 1'b1;
      BRANCH: begin
        o_aluSrcA     = 1'b1;
        o_aluOp       = 2'b01;
        o_pcWriteCond = 1'b1;
        o_pcSrc       = 2'b01;
`ifdef CTRL_BNE_EN
        o_branchNe    = bne_q;
`endif
      end
      JUMP: begin
        o_pcWrite = 1'b1;
        o_pcSrc   = 2'b10;
      end
      FAULT:  o_fault = 1'b1;
      default: ;
    endcase
  end

  assign o_state = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide parameter WAIT_W, default 4: width of the memory-wait counter; timeout at count 2^WAIT_W-1.
REQ-002 SHALL have clock i_clk (one clock); reset is synchronous and active-high; reset port is i_rst.
REQ-003 i_clk  in  1  sole clock, all state on rising edge.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_instrCode  in  32  instruction register contents.
REQ-006 i_memReady  in  1  memory completes the current read/write this cycle.
REQ-007 o_pcWrite  out  1  unconditional PC load.
REQ-008 o_pcWriteCond  out  1  PC load qualified by datapath zero flag.
REQ-009 o_branchNe  out  1  invert zero qualification (bne).
REQ-010 o_iorD  out  1  memory address: 0 = PC, 1 = ALUOut.
REQ-011 o_memRead / o_memWrite  out  1 each  memory request strobes.
REQ-012 o_irWrite  out  1  load instruction register.
REQ-013 o_memToReg / o_regDst / o_regWrite  out  1 each  register-file write controls.
REQ-014 o_aluSrcA  out  1  0 = PC, 1 = rs.
REQ-015 o_aluSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-016 o_aluOp  out  2  00 add, 01 sub, 10 use funct.
REQ-017 o_pcSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-018 o_func  out  6  i_instrCode[5:0], combinational.
REQ-019 o_state  out  4  current state encoding.
REQ-020 o_fault  out  1  high while in FAULT.

Function
REQ-021 Moore FSM; all outputs except o_func decode from the state register, plus i_memReady gating per REQ-023; unlisted outputs are 0.
REQ-022 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IMMEX 10, IMMWB 11, FAULT 15.
REQ-023 FETCH: memRead=1, iorD=0, aluSrcB=01, aluOp=00, pcSrc=00; irWrite and pcWrite assert only when i_memReady=1; advance to DECODE on i_memReady.
REQ-024 DECODE: aluSrcB=11, aluOp=00; one cycle; dispatch on i_instrCode[31:26]: 000000->EXEC, 100011/101011->MEMADR, 001000/001001->IMMEX, 000100->BRANCH, 000010->JUMP, others->FAULT.
REQ-025 MEMADR: aluSrcA=1, aluSrcB=10; ->MEMRD if opcode 100011, else MEMWR.
REQ-026 MEMRD: memRead=1, iorD=1; ->MEMWB on i_memReady. MEMWB: regWrite=1, memToReg=1, regDst=0; ->FETCH.
REQ-027 MEMWR: memWrite=1, iorD=1; ->FETCH on i_memReady.
REQ-028 EXEC: aluSrcA=1, aluSrcB=00, aluOp=10; ->ALUWB. ALUWB: regWrite=1, regDst=1; ->FETCH.
REQ-029 IMMEX: aluSrcA=1, aluSrcB=10, aluOp=00; ->IMMWB. IMMWB: regWrite=1, regDst=0; ->FETCH.
REQ-030 BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSrc=01; ->FETCH. JUMP: pcWrite=1, pcSrc=10; ->FETCH.
REQ-031 Wait counter (WAIT_W bits) clears on entry to FETCH/MEMRD/MEMWR and on i_memReady; increments each cycle the state waits with i_memReady=0.
REQ-032 Counter at 2^WAIT_W-1 with i_memReady=0 -> FAULT next cycle, no strobes issued that cycle beyond the request; i_memReady=1 in that same cycle wins (normal advance).
REQ-033 FAULT is sticky: all strobes 0, o_fault=1, exit only via i_rst.
REQ-034 Total latency with zero-wait memory: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3.

Reset
REQ-035 i_rst=1 at a clock edge forces state FETCH and counter 0, aborting any in-flight state including FAULT and pending memory waits.
REQ-036 During and after reset: o_state=0, o_fault=0, o_memRead=1, all write strobes 0 until i_memReady.

Configuration
REQ-037 Macro CTRL_BNE_EN defined: opcode 000101 dispatches to BRANCH with o_branchNe=1 in that state.
REQ-038 Macro undefined: opcode 000101 ->FAULT; o_branchNe tied 0; port remains present.

Verification
REQ-039 Reset, then add (0x012A4020), i_memReady=1 always -> states 0,1,6,7,0; regWrite=1, regDst=1 in state 7 only.
REQ-040 lw 0x8D090004 with i_memReady low 3 cycles in MEMRD -> memRead held 4 cycles, state 4 then regWrite=1, memToReg=1.
REQ-041 i_memReady held 0 in FETCH, WAIT_W=4 -> FAULT (o_state=15, o_fault=1) after 16 cycles; irWrite never asserted; i_rst recovers to state 0.
REQ-042 beq 0x11090003 -> states 0,1,8; pcWriteCond=1, aluOp=01, pcSrc=01 in state 8; with CTRL_BNE_EN, bne 0x15090003 additionally o_branchNe=1.
REQ-043 Opcode 0x3F in DECODE -> FAULT; i_rst asserted mid-MEMWR -> next state FETCH, memWrite=0.
